// File: rtl/act_pack_pkg.sv
// Shared constants and types for the activation write-back path: data width,
// the ReLU saturation ceiling and the default packing/requantize settings.
package act_pack_pkg;

  localparam int DATA_LEN      = 8;
  localparam int ACT_MAX       = (1 << (DATA_LEN - 1)) - 1;
  localparam int PACK_DEFAULT  = 4;
  localparam int SHIFT_DEFAULT = 4;

  typedef logic signed [DATA_LEN-1:0] data_t;
  typedef logic signed [DATA_LEN:0]   sum_t;

endpackage

// File: rtl/act_pack_relu_requant.sv
// Combinational datapath: widening bias add, and arithmetic requantize shift
// followed by ReLU and saturation. The two halves sit on either side of a register.
module act_pack_relu_requant
  import act_pack_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  data_t in_q,
  input  data_t bias,
  output sum_t  sum,
  input  sum_t  sum_in,
  output data_t act
);

  sum_t shifted;

  always_comb begin
    sum     = sum_t'(in_q) + sum_t'(bias);
    shifted = sum_in >>> SHIFT;
    if (shifted < 0) begin
      act = '0;
    end else if (shifted > sum_t'(ACT_MAX)) begin
      act = data_t'(ACT_MAX);
    end else begin
      act = shifted[DATA_LEN-1:0];
    end
  end

endmodule

// File: rtl/act_pack.sv
// Accepts one dot-product result per rising edge of in_valid, requantizes it
// through a three-stage pipeline and packs PACK activations per output word.
module act_pack
  import act_pack_pkg::*;
#(
  parameter int PACK  = PACK_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_LEN-1:0]        in_q,
  input  logic [DATA_LEN-1:0]        bias,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [PACK*DATA_LEN-1:0]   out_q,
  output logic [$clog2(PACK):0]      out_lanes,
  output logic [15:0]                word_cnt
);

  localparam int PW = $clog2(PACK);

  typedef logic [PACK-1:0][DATA_LEN-1:0] word_t;

  logic          in_valid_q;
  logic          cap_valid_q, cap_valid_d;
  data_t         in_cap_q, in_cap_d;
  data_t         bias_cap_q, bias_cap_d;
  logic          s1_valid_q, s1_valid_d;
  sum_t          sum_q, sum_d;
  logic          s2_valid_q, s2_valid_d;
  data_t         act_q, act_d;
  logic [PW-1:0] ptr_q, ptr_d;
  word_t         lanes_q, lanes_d;
  logic          flush_pending_q, flush_pending_d;
  logic          out_valid_q, out_valid_d;
  word_t         out_q_q, out_q_d;
  logic [PW:0]   out_lanes_q, out_lanes_d;
  logic [15:0]   word_cnt_q, word_cnt_d;

  logic          take;
  logic          flush_exec;
  sum_t          sum_w;
  data_t         act_w;

  act_pack_relu_requant #(.SHIFT(SHIFT)) u_relu_requant (
    .in_q   (in_cap_q),
    .bias   (bias_cap_q),
    .sum    (sum_w),
    .sum_in (sum_q),
    .act    (act_w)
  );

  always_comb begin
    take            = in_valid & ~in_valid_q;
    cap_valid_d     = take;
    in_cap_d        = take ? data_t'(in_q) : in_cap_q;
    bias_cap_d      = take ? data_t'(bias) : bias_cap_q;
    s1_valid_d      = cap_valid_q;
    sum_d           = cap_valid_q ? sum_w : sum_q;
    s2_valid_d      = s1_valid_q;
    act_d           = s1_valid_q ? act_w : act_q;
    ptr_d           = ptr_q;
    lanes_d         = lanes_q;
    out_valid_d     = 1'b0;
    out_q_d         = out_q_q;
    out_lanes_d     = out_lanes_q;
    word_cnt_d      = word_cnt_q;

    // A flush waits until every result already accepted has reached the packer.
    flush_exec      = flush_pending_q & ~cap_valid_q & ~s1_valid_q & ~s2_valid_q & ~take;
    flush_pending_d = (flush_pending_q & ~flush_exec) | flush;

    if (s2_valid_q) begin
      lanes_d[ptr_q] = act_q;
      if (ptr_q == PW'(PACK - 1)) begin
        out_q_d     = lanes_d;
        out_valid_d = 1'b1;
        out_lanes_d = (PW + 1)'(PACK);
        ptr_d       = '0;
        word_cnt_d  = word_cnt_q + 16'd1;
        lanes_d     = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end else if (flush_exec && ptr_q != '0) begin
      out_q_d     = lanes_q;
      out_valid_d = 1'b1;
      out_lanes_d = {1'b0, ptr_q};
      ptr_d       = '0;
      word_cnt_d  = word_cnt_q + 16'd1;
      lanes_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid_q      <= 1'b0;
      cap_valid_q     <= 1'b0;
      in_cap_q        <= '0;
      bias_cap_q      <= '0;
      s1_valid_q      <= 1'b0;
      sum_q           <= '0;
      s2_valid_q      <= 1'b0;
      act_q           <= '0;
      ptr_q           <= '0;
      lanes_q         <= '0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_q_q         <= '0;
      out_lanes_q     <= '0;
      word_cnt_q      <= '0;
    end else begin
      in_valid_q      <= in_valid;
      cap_valid_q     <= cap_valid_d;
      in_cap_q        <= in_cap_d;
      bias_cap_q      <= bias_cap_d;
      s1_valid_q      <= s1_valid_d;
      sum_q           <= sum_d;
      s2_valid_q      <= s2_valid_d;
      act_q           <= act_d;
      ptr_q           <= ptr_d;
      lanes_q         <= lanes_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
      out_q_q         <= out_q_d;
      out_lanes_q     <= out_lanes_d;
      word_cnt_q      <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_lanes = out_lanes_q;
  assign word_cnt  = word_cnt_q;

endmodule
